// File: rtl/usb_full_speed_endpoint_collector_pkg.sv
// Shared types for the full-speed OUT endpoint collector: handshake codes, DATA PIDs, FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package usbFullSpeedPkg;

  typedef enum logic [1:0] {
    HS_ACK   = 2'd0,
    HS_NAK   = 2'd1,
    HS_STALL = 2'd2
  } hs_e;

  localparam logic PID_DATA0 = 1'b0;
  localparam logic PID_DATA1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DROP    = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/usb_full_speed_endpoint_collector_if.sv
// Bus between packet layer / downstream receiver and the endpoint collector.
// Latency: n/a (wiring only).
// Backpressure: only the delivery side (o_erValid/i_erReady) can stall; byte stream cannot.
interface usb_full_speed_endpoint_collector_if #(
  parameter int MAX_PKT = 8
);
  localparam int CW = $clog2(MAX_PKT) + 1;

  logic                 i_pktStart;
  logic                 i_pktPid;
  logic                 i_byteValid;
  logic [7:0]           i_byte;
  logic                 i_pktEnd;
  logic                 i_pktCrcOk;
  logic                 i_pktAbort;
  logic                 i_toggleClr;
  logic                 i_erStall;
  logic                 o_hsValid;
  logic [1:0]           o_hs;
  logic                 o_erValid;
  logic                 i_erReady;
  logic [8*MAX_PKT-1:0] o_erData;
  logic [CW-1:0]        o_erData_nBytes;
  logic [7:0]           o_nCrcErr;
  logic [7:0]           o_nOverflow;

  // packet layer plus downstream receiver side
  modport master (
    output i_pktStart, i_pktPid, i_byteValid, i_byte, i_pktEnd, i_pktCrcOk,
           i_pktAbort, i_toggleClr, i_erStall, i_erReady,
    input  o_hsValid, o_hs, o_erValid, o_erData, o_erData_nBytes, o_nCrcErr, o_nOverflow
  );

  // collector side
  modport slave (
    input  i_pktStart, i_pktPid, i_byteValid, i_byte, i_pktEnd, i_pktCrcOk,
           i_pktAbort, i_toggleClr, i_erStall, i_erReady,
    output o_hsValid, o_hs, o_erValid, o_erData, o_erData_nBytes, o_nCrcErr, o_nOverflow
  );

endinterface

// File: rtl/usb_full_speed_endpoint_collector_pkt_bank.sv
// One packet bank: byte-indexed write at the running count, cleared at packet start.
// Latency: a written byte and the new count are visible the cycle after wr_en.
// Backpressure: none; writes while full are dropped (the owner flags overflow from full).
module usb_full_speed_pkt_bank #(
  parameter int MAX_PKT = 8,
  parameter int CW      = $clog2(MAX_PKT) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [7:0]           wr_byte,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic [8*MAX_PKT-1:0] data
);

  logic [CW-2:0] idx;

  assign idx  = count[CW-2:0];
  assign full = (count == CW'(MAX_PKT));

  // clear has priority over a write; bytes past full never land
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      data  <= '0;
    end else if (clr) begin
      count <= '0;
      data  <= '0;
    end else if (wr_en && !full) begin
      data[idx*8 +: 8] <= wr_byte;
      count            <= count + 1'b1;
    end
  end

endmodule

// File: rtl/usb_full_speed_endpoint_collector.sv
// Collects full-speed OUT DATA packets into ping-pong banks, checks CRC/toggle, decides ACK/NAK/STALL.
// Latency: handshake strobe and delivery both appear one cycle after EOP.
// Backpressure: a delivered packet holds until i_erReady; packets arriving meanwhile are NAKed.
// Optional: USB_EP_COLLECT_STATS_EN enables the saturating CRC-error and overflow counters.
module usb_full_speed_endpoint_collector #(
  parameter int MAX_PKT = 8
) (
  input logic i_clk,
  input logic i_rst_n,
  usb_full_speed_endpoint_collector_if.slave ep
);
  import usbFullSpeedPkg::*;

  localparam int CW = $clog2(MAX_PKT) + 1;

  state_e state, state_nxt;

  logic          exp_toggle;
  logic          rd_bank;
  logic          pkt_pid;
  logic          drop_hs_vld;
  hs_e           drop_hs;
  logic          er_valid;
  logic [CW-1:0] er_nbytes;
  logic          hs_valid;
  hs_e           hs;

  // per-cycle decisions from the FSM
  logic start_take;
  logic start_drop;
  hs_e  start_hs;
  logic byte_wr;
  logic ovf_evt;
  logic crc_evt;
  logic hs_fire;
  hs_e  hs_nxt;
  logic deliver;

  // bank plumbing; the write bank is always the one not being presented
  logic                 wr_bank;
  logic                 clr0, clr1, wr0, wr1, full0, full1;
  logic [CW-1:0]        cnt0, cnt1;
  logic [8*MAX_PKT-1:0] dat0, dat1;
  logic                 wr_full;
  logic [CW-1:0]        wr_cnt;

  assign wr_bank = ~rd_bank;
  assign wr_full = wr_bank ? full1 : full0;
  assign wr_cnt  = wr_bank ? cnt1  : cnt0;
  assign clr0    = start_take & ~wr_bank;
  assign clr1    = start_take &  wr_bank;
  assign wr0     = byte_wr    & ~wr_bank;
  assign wr1     = byte_wr    &  wr_bank;

  usb_full_speed_pkt_bank #(.MAX_PKT(MAX_PKT)) u_bank0 (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr     (clr0),
    .wr_en   (wr0),
    .wr_byte (ep.i_byte),
    .count   (cnt0),
    .full    (full0),
    .data    (dat0)
  );

  usb_full_speed_pkt_bank #(.MAX_PKT(MAX_PKT)) u_bank1 (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr     (clr1),
    .wr_en   (wr1),
    .wr_byte (ep.i_byte),
    .count   (cnt1),
    .full    (full1),
    .data    (dat1)
  );

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // next state and per-cycle actions; abort beats everything, a new start pre-empts any packet
  always_comb begin
    state_nxt  = state;
    start_take = 1'b0;
    start_drop = 1'b0;
    start_hs   = HS_NAK;
    byte_wr    = 1'b0;
    ovf_evt    = 1'b0;
    crc_evt    = 1'b0;
    hs_fire    = 1'b0;
    hs_nxt     = hs;
    deliver    = 1'b0;
    if (ep.i_pktAbort) begin
      state_nxt = ST_IDLE;
    end else if (ep.i_pktStart) begin
      if (ep.i_erStall) begin
        state_nxt  = ST_DROP;
        start_drop = 1'b1;
        start_hs   = HS_STALL;
      end else if (er_valid) begin
        state_nxt  = ST_DROP;
        start_drop = 1'b1;
        start_hs   = HS_NAK;
      end else begin
        state_nxt  = ST_COLLECT;
        start_take = 1'b1;
      end
    end else begin
      case (state)
        ST_IDLE: ;
        ST_COLLECT: begin
          if (ep.i_pktEnd) begin
            state_nxt = ST_RESP;
            crc_evt   = ~ep.i_pktCrcOk;
            if (!crc_evt) begin
              hs_fire = 1'b1;
              hs_nxt  = HS_ACK;
              // a toggle mismatch is a retransmission: ACK it but keep the old data
              deliver = (pkt_pid == exp_toggle);
            end
          end else if (ep.i_byteValid) begin
            if (wr_full) begin
              state_nxt = ST_DROP;
              ovf_evt   = 1'b1;
            end else begin
              byte_wr = 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (ep.i_pktEnd) begin
            state_nxt = ST_RESP;
            crc_evt   = ~ep.i_pktCrcOk;
            if (!crc_evt && drop_hs_vld) begin
              hs_fire = 1'b1;
              hs_nxt  = drop_hs;
            end
          end
        end
        ST_RESP: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // packet context: PID and the handshake owed by a dropped packet (none after overflow)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_pid     <= PID_DATA0;
      drop_hs_vld <= 1'b0;
      drop_hs     <= HS_NAK;
    end else begin
      if (ep.i_pktStart && !ep.i_pktAbort) pkt_pid <= ep.i_pktPid;
      if (start_drop) begin
        drop_hs_vld <= 1'b1;
        drop_hs     <= start_hs;
      end else if (ovf_evt) begin
        drop_hs_vld <= 1'b0;
      end
    end
  end

  // handshake strobe, delivery handshake, bank swap and data toggle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_valid   <= 1'b0;
      hs         <= HS_ACK;
      er_valid   <= 1'b0;
      er_nbytes  <= '0;
      rd_bank    <= 1'b0;
      exp_toggle <= PID_DATA0;
    end else begin
      hs_valid <= hs_fire;
      if (hs_fire) hs <= hs_nxt;
      if (deliver) begin
        er_valid  <= 1'b1;
        er_nbytes <= wr_cnt;
        rd_bank   <= ~rd_bank;
      end else if (er_valid && ep.i_erReady) begin
        er_valid <= 1'b0;
      end
      // an explicit clear overrides a flip from the same packet
      if (ep.i_toggleClr)  exp_toggle <= PID_DATA0;
      else if (deliver)    exp_toggle <= (exp_toggle == PID_DATA0) ? PID_DATA1 : PID_DATA0;
    end
  end

  assign ep.o_hsValid       = hs_valid;
  assign ep.o_hs            = hs;
  assign ep.o_erValid       = er_valid;
  assign ep.o_erData        = rd_bank ? dat1 : dat0;
  assign ep.o_erData_nBytes = er_nbytes;

`ifdef USB_EP_COLLECT_STATS_EN
  logic [7:0] n_crc_err;
  logic [7:0] n_overflow;

  // saturating error counters
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      n_crc_err  <= '0;
      n_overflow <= '0;
    end else begin
      if (crc_evt) n_crc_err  <= sat_inc8(n_crc_err);
      if (ovf_evt) n_overflow <= sat_inc8(n_overflow);
    end
  end

  assign ep.o_nCrcErr   = n_crc_err;
  assign ep.o_nOverflow = n_overflow;
`else
  assign ep.o_nCrcErr   = 8'd0;
  assign ep.o_nOverflow = 8'd0;
`endif

endmodule
